// File: rtl/write_back_buffer.sv
// Register-file write-back buffer: FIFO of pending writes drained onto the single
// write port, with two youngest-match forwarding lookups for decode.
module write_back_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_alu_result,
    input  logic [31:0]        in_mem_data,
    input  logic [4:0]         in_dest_reg,
    input  logic               in_ctrl_memToReg,
    input  logic               in_ctrl_regWrite,
    input  logic               wb_stall,
    input  logic               flush,
    output logic [31:0]        write_data_into_reg,
    output logic [4:0]         write_register,
    output logic               ctrl_regWrite,
    input  logic [4:0]         fwd_query_1,
    input  logic [4:0]         fwd_query_2,
    output logic               fwd_hit_1,
    output logic               fwd_hit_2,
    output logic [31:0]        fwd_data_1,
    output logic [31:0]        fwd_data_2,
    output logic [PTR_W:0]     count
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_c, push_c, pop_c;
    logic [DATA_W-1:0] in_data_c;

    assign empty_c   = (count_q == '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign pop_c     = !empty_c && !wb_stall;
    // Items that write no register (or r0) are accepted but never stored.
    assign push_c    = in_valid && in_ready && in_ctrl_regWrite &&
                       (in_dest_reg != '0) && !flush;
    assign in_data_c = in_ctrl_memToReg ? in_mem_data : in_alu_result;

    assign ctrl_regWrite       = pop_c;
    assign write_data_into_reg = empty_c ? '0 : data_q[rd_ptr_q];
    assign write_register      = empty_c ? '0 : dest_q[rd_ptr_q];
    assign count               = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_c) begin
                data_q[wr_ptr_q] <= in_data_c;
                dest_q[wr_ptr_q] <= in_dest_reg;
            end
        end
    end

    // Walk occupied entries oldest to youngest so the youngest match is left standing.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = '0;
        fwd_data_2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((fwd_query_1 != '0) &&
                    (dest_q[PTR_W'(rd_ptr_q + PTR_W'(i))] == fwd_query_1)) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = data_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
                end
                if ((fwd_query_2 != '0) &&
                    (dest_q[PTR_W'(rd_ptr_q + PTR_W'(i))] == fwd_query_2)) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = data_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
                end
            end
        end
    end

endmodule
